// File: rtl/bus_arbiter.sv
// Shares one Wishbone-style bus between the IF fetch port and the MEM data port.
// MEM has fixed priority; read data is held until the stalled stage releases it.
module bus_arbiter #(
  parameter int TO_W = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  stall,
  input  logic        flush,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_stallreq,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [3:0]  mem_sel,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_stallreq,
  output logic        bus_cyc,
  output logic        bus_stb,
  output logic        bus_we,
  output logic [3:0]  bus_sel,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        bus_err
);

  typedef enum logic [2:0] {
    IDLE, IF_ACC, MEM_ACC, IF_HOLD, MEM_HOLD
  } state_t;

  localparam logic [TO_W-1:0] WD_ONE  = TO_W'(1);
  // Timeout fires on the edge that would bring the counter to all-ones.
  localparam logic [TO_W-1:0] WD_LAST = ~WD_ONE;

  state_t          state;
  logic [TO_W-1:0] wdog;
  logic            kill;
  logic [31:0]     if_rd_q;
  logic [31:0]     mem_rd_q;
  logic            timeout;

  assign timeout = (wdog == WD_LAST);

  // NOTE: stall requests stay combinational so the pipeline sees a new request
  // (or a flush) in the same cycle, not one cycle late.
  assign if_stallreq  = if_req  & ~flush & (state != IF_HOLD);
  assign mem_stallreq = mem_req & ~flush & (state != MEM_HOLD);

  assign if_rdata  = if_rd_q;
  assign mem_rdata = mem_rd_q;

  // NOTE: every register here, read-data holders included, takes the async reset;
  // these are a handful of flops, not a RAM, so there is no reason to leave them X.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      wdog      <= '0;
      kill      <= 1'b0;
      if_rd_q   <= '0;
      mem_rd_q  <= '0;
      bus_cyc   <= 1'b0;
      bus_stb   <= 1'b0;
      bus_we    <= 1'b0;
      bus_sel   <= '0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      bus_err   <= 1'b0;
    end else begin
      bus_err <= 1'b0;
      unique case (state)
        IDLE: begin
          kill <= 1'b0;
          wdog <= '0;
          if (mem_req && !flush) begin
            state     <= MEM_ACC;
            bus_cyc   <= 1'b1;
            bus_stb   <= 1'b1;
            bus_we    <= mem_we;
            bus_sel   <= mem_sel;
            bus_addr  <= mem_addr;
            bus_wdata <= mem_wdata;
          end else if (if_req && !flush) begin
            state     <= IF_ACC;
            bus_cyc   <= 1'b1;
            bus_stb   <= 1'b1;
            bus_we    <= 1'b0;
            bus_sel   <= 4'hF;
            bus_addr  <= if_addr;
            bus_wdata <= '0;
          end
        end

        IF_ACC, MEM_ACC: begin
          // A flush never cuts the bus cycle short; it only marks the result as dead.
          if (flush) kill <= 1'b1;
          if (bus_ack || timeout) begin
            bus_cyc <= 1'b0;
            bus_stb <= 1'b0;
            bus_we  <= 1'b0;
            wdog    <= '0;
            bus_err <= ~bus_ack;
            if (kill || flush) begin
              state <= IDLE;
              kill  <= 1'b0;
            end else if (state == MEM_ACC) begin
              state    <= MEM_HOLD;
              mem_rd_q <= bus_ack ? bus_rdata : '0;
            end else begin
              state   <= IF_HOLD;
              if_rd_q <= bus_ack ? bus_rdata : '0;
            end
          end else begin
            wdog <= wdog + WD_ONE;
          end
        end

        IF_HOLD:  if (flush || !stall[1]) state <= IDLE;
        MEM_HOLD: if (flush || !stall[4]) state <= IDLE;
        default:  state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Shares a single Wishbone-style memory bus between the instruction-fetch port and the MEM-stage data port of the five-stage core. It sequences each access with an FSM and raises per-requester stall requests toward the pipeline controller. It holds read data stable until the stalled stage consumes it, aborts hung accesses with a watchdog, and honours pipeline flushes. It sits between the IF/MEM stages, the stall controller, and the external bus.

## Interface
- `TO_W`, default 8: watchdog counter width; an access times out after 2^TO_W−1 cycles without ack.
- `clk` in 1: clock, all state on rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `stall` in 6: pipeline stall vector from the controller. Bit 1 is the IF stage, bit 4 is the MEM stage.
- `flush` in 1: pipeline flush (exception/eret).
- `if_req` in 1: fetch request.
- `if_addr` in 32: fetch address.
- `if_rdata` out 32: fetched instruction.
- `if_stallreq` out 1: fetch not ready.
- `mem_req` in 1: data request.
- `mem_we` in 1: data write.
- `mem_sel` in 4: byte enables.
- `mem_addr` in 32: data address.
- `mem_wdata` in 32: write data.
- `mem_rdata` out 32: load data.
- `mem_stallreq` out 1: data not ready.
- `bus_cyc`, `bus_stb`, `bus_we` out 1: bus control, registered.
- `bus_sel` out 4: bus byte enables, registered.
- `bus_addr`, `bus_wdata` out 32: bus address and write data, registered.
- `bus_ack` in 1: bus acknowledge.
- `bus_rdata` in 32: bus read data.
- `bus_err` out 1: one-cycle pulse on watchdog abort.

## Operation
- States: IDLE, IF_ACC, MEM_ACC, IF_HOLD, MEM_HOLD.
- **IDLE:**
  - `mem_req & ~flush` → MEM_ACC. Latch `mem_we/sel/addr/wdata` onto the bus and set `bus_cyc = bus_stb = 1`.
  - Otherwise, `if_req & ~flush` → IF_ACC with `bus_we = 0` and `bus_sel = 4'hF`.
  - MEM has fixed priority. IF waits while MEM is active.
- **x_ACC** (x = IF or MEM): the bus is held constant and the watchdog increments every cycle.
  - On `bus_ack`: drop `cyc/stb/we`, latch `bus_rdata` into the x read register, clear the watchdog, go to x_HOLD.
  - On watchdog reaching 2^TO_W−1 without ack: drop the bus, load 0 into the x read register, pulse `bus_err`, go to x_HOLD.
- **x_HOLD:** the read register drives `x_rdata`.
  - IF_HOLD → IDLE when `stall[1] == 0`.
  - MEM_HOLD → IDLE when `stall[4] == 0`.
  - `flush` → IDLE.
- **Flush during x_ACC:**
  - The bus access is not aborted; it runs to ack or timeout, so writes are never truncated.
  - A kill flag is set. On completion, the FSM goes to IDLE instead of HOLD and the data is discarded.
  - The kill flag clears on entering IDLE.
- **Stall requests (combinational):**
  - `if_stallreq = if_req & ~flush & (state != IF_HOLD)`.
  - `mem_stallreq = mem_req & ~flush & (state != MEM_HOLD)`.
- **Read data:** `if_rdata` and `mem_rdata` always show their own read register. Each register is updated only on completion of an access of its own type.
- **Simultaneous events:**
  - `mem_req` and `if_req` both high in IDLE: MEM is served first.
  - `bus_ack` and timeout in the same cycle: ack wins, data is latched, no `bus_err`.
  - `flush` and `bus_ack` in the same cycle: the access is discarded, next state is IDLE.
- **Reset (asynchronous, any state, mid-access included):**
  - State → IDLE; all bus outputs, `bus_err`, read registers, watchdog and kill flag → 0.
  - `if_stallreq` and `mem_stallreq` follow their equations.

## Timing
- Request sampled in IDLE at edge N → `bus_stb` high after edge N.
- `bus_ack` sampled at edge M → bus released and `x_rdata` valid after edge M; stallreq low in the same interval.
- Zero-wait-state slave (ack in the first stb cycle): 2 cycles from request to stallreq low.
- Back-to-back: HOLD → IDLE → next ACC adds one IDLE cycle between accesses.
- Watchdog abort: `bus_err` high for exactly the one cycle after the abort edge.

## Test plan
- **Reset:** assert `rst_n = 0` mid-MEM_ACC → `bus_cyc = 0`, `bus_err = 0`, `mem_rdata = 0` immediately, without waiting for a clock edge.
- **Single fetch:** `if_req = 1`, `if_addr = 0x00000100`, ack 2 cycles later with `bus_rdata = 0x3C011234`.
  - `bus_addr = 0x100`, `bus_sel = F`, `bus_we = 0` during the access.
  - After ack: `if_rdata = 0x3C011234` and `if_stallreq` falls.
  - `stall[1] = 1` for 3 more cycles keeps the data held; the FSM returns to IDLE when `stall[1] = 0`.
- **Contention:** `if_req` and `mem_req` (store of `0xDEADBEEF` to `0x80`, `sel = 4'b0011`) in the same cycle.
  - The MEM access runs first with `bus_we = 1`.
  - After MEM_HOLD releases, the IF access starts; `if_stallreq` is high throughout the MEM access.
- **Timeout:** `TO_W = 3`, `mem_req` load, never ack → bus drops after 7 cycles, `bus_err` pulses once, `mem_rdata = 0`.
- **Flush mid-access:** `flush` pulses during IF_ACC.
  - `if_stallreq` goes low during the flush.
  - The bus stays asserted until ack; `if_rdata` is unchanged; the next state is IDLE.
- **Ack/timeout tie:** `TO_W = 2`, ack on the 3rd cycle → data is latched and `bus_err` stays 0.
